alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the per-thread ALU, one instance per thread per core.
- Executes ADD/SUB/MUL/DIV/CMP on DATA_WIDTH operands under a valid/ready issue handshake with a one-cycle response pulse.
- DIV is an iterative restoring divider, so the core scheduler must wait for resp_valid instead of assuming fixed latency.
- CMP produces correct unsigned NZP flags. Divide-by-zero is defined, not undefined.

Parameters:
- DATA_WIDTH, 8, operand and result width (≥2).
- CNT_W, $clog2(DATA_WIDTH+1), width of the divide iteration counter (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  thread active in current block. When 0, requests are ignored and req_ready=0.
- req_valid  in  1  operation request
- req_ready  out  1  ALU can accept a request this cycle
- req_op  in  3  0=ADD 1=SUB 2=MUL 3=DIV 4=CMP; 5-7 reserved
- rs  in  DATA_WIDTH  operand A
- rt  in  DATA_WIDTH  operand B
- resp_valid  out  1  one-cycle pulse: alu_out/div_zero valid
- alu_out  out  DATA_WIDTH  result, held until the next response
- div_zero  out  1  last DIV had rt==0, held until the next response

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is synchronous, active-high, with priority over everything.
- Reset values: alu_out=0, div_zero=0, resp_valid=0, state=IDLE, counter=0. req_ready is 0 during the reset cycle.
- req_ready = enable && state==IDLE && !reset. This is combinational from state, not from req_valid.
- Accept occurs on an edge where req_valid && req_ready. rs, rt and req_op are captured at accept and need not remain stable afterwards.
- ADD/SUB/MUL:
  - Result is computed at the accept edge: modulo 2^DATA_WIDTH, low half of the product for MUL.
  - resp_valid is high the next cycle (latency 1). div_zero is cleared.
- CMP:
  - Unsigned compare.
  - alu_out = {zeros, P, Z, N}: bit2 = rs>rt, bit1 = rs==rt, bit0 = rs<rt. Exactly one bit is set.
  - Latency 1. div_zero is cleared.
- DIV, rt!=0:
  - State goes IDLE→DIV and the counter loads DATA_WIDTH.
  - One restoring-division step per edge. At the edge where the counter reaches 0: alu_out=quotient, div_zero=0, state→IDLE, resp_valid high the next cycle.
  - Latency DATA_WIDTH+1 cycles from the accept cycle.
  - The remainder is internal and not exported.
- DIV, rt==0: alu_out = all ones, div_zero=1, latency 1, no DIV state entered.
- Reserved op: treated as ADD.
- resp_valid is a single-cycle pulse. There is no backpressure on the response.
- Back-to-back issue: a new request may be accepted in the same cycle resp_valid is high (state is already IDLE). Throughput is 1 op/cycle for non-DIV ops.
- alu_out and div_zero change only on a response-producing edge. No intermediate divider values are visible.
- enable deasserted mid-DIV: the divide completes normally. enable gates acceptance only.
- reset mid-DIV: aborts immediately. Outputs return to reset values and no resp_valid is produced for the aborted op.
- States: IDLE, DIV. There are no other states. An illegal encoding returns to IDLE.

Decomposition:
- Package alu_pkg holds:
  - the alu_op_e enum (ADD, SUB, MUL, DIV, CMP);
  - the alu_state_e enum (IDLE, DIV);
  - the NZP bit-position localparams (NZP_N=0, NZP_Z=1, NZP_P=2).
- Sub-module alu_divider (iterative restoring, DATA_WIDTH-parametrised):
  - inputs start, dividend, divisor;
  - outputs done, quotient;
  - owns the counter and the partial-remainder registers.
- alu_mc holds the handshake FSM, the single-cycle datapath and the output registers.

Test Plan:
- Reset then idle with enable=1: alu_out=0, resp_valid=0, req_ready=1 on the first post-reset cycle.
- ADD 200+100 (W=8): alu_out=44, resp_valid one cycle after accept. Then MUL 16*17 issued back-to-back: alu_out=16 (272 mod 256) the next cycle.
- CMP:
  - rs=5, rt=9 → alu_out=0b001;
  - rs=9, rt=9 → 0b010;
  - rs=200, rt=3 → 0b100 (unsigned, not negative).
- DIV 200/7: req_ready=0 for 8 cycles. Then resp_valid in cycle 9 after accept, alu_out=28, div_zero=0. A req_valid held throughout is accepted on that cycle.
- DIV 77/0: alu_out=255, div_zero=1, latency 1. A following ADD 1+1 gives alu_out=2 and clears div_zero.
- DIV 255/1 with reset asserted 4 cycles after accept: no resp_valid. alu_out=0, req_ready=1 the cycle after reset deasserts. A fresh SUB 3-5 returns 254.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle per-thread ALU:
//   alu_op_e    - request opcode encoding (codes 5-7 are reserved)
//   alu_state_e - handshake FSM states
//   NZP_*       - bit positions of the compare flags in alu_out
// ----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_CMP = 3'd4
   } alu_op_e;

   // Two bits wide so that an illegal encoding exists and is recovered from.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1
   } alu_state_e;

   localparam int NZP_N = 0;   // rs <  rt
   localparam int NZP_Z = 1;   // rs == rt
   localparam int NZP_P = 2;   // rs >  rt

endpackage

// File: rtl/alu_divider.sv
// ----------------------------------------------------------------------------
// alu_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (aborts a divide in flight)
//   start     in   load dividend/divisor and begin DATA_WIDTH steps
//   dividend  in   DATA_WIDTH  numerator (captured on start)
//   divisor   in   DATA_WIDTH  denominator (captured on start, must be != 0)
//   done      out  high in the cycle whose closing edge performs the last step
//   quotient  out  DATA_WIDTH  quotient produced by that last step
//
// done and quotient are combinational look-ahead of the final step, so the
// parent can register the quotient on the very edge the counter reaches 0.
// ----------------------------------------------------------------------------
module alu_divider #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient
);

   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] rem_q;    // partial remainder, always < divisor
   logic [DATA_WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits in the bottom
   logic [DATA_WIDTH-1:0] dvs_q;

   logic [DATA_WIDTH:0]   rem_shift;
   logic                  fits;
   logic [DATA_WIDTH-1:0] rem_d;
   logic [DATA_WIDTH-1:0] quo_d;

   always_comb begin
      rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
      fits      = (rem_shift >= {1'b0, dvs_q});
      // When the divisor fits, the difference is below the divisor and so
      // fits in DATA_WIDTH bits; the dropped carry is always zero.
      rem_d     = fits ? (rem_shift[DATA_WIDTH-1:0] - dvs_q) : rem_shift[DATA_WIDTH-1:0];
      quo_d     = {quo_q[DATA_WIDTH-2:0], fits};
   end

   assign done     = (cnt_q == CNT_W'(1));
   assign quotient = quo_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (start) begin
         cnt_q <= CNT_W'(DATA_WIDTH);
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
         rem_q <= rem_d;
         quo_q <= quo_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc
// Multi-cycle per-thread ALU: ADD/SUB/MUL/CMP complete in one cycle, DIV runs
// an iterative divider and completes DATA_WIDTH+1 cycles after accept.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   enable      in   thread active; gates acceptance only
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_op      in   3   0=ADD 1=SUB 2=MUL 3=DIV 4=CMP, 5-7 behave as ADD
//   rs, rt      in   DATA_WIDTH operands, captured at accept
//   resp_valid  out  one-cycle response pulse
//   alu_out     out  DATA_WIDTH result, held until the next response
//   div_zero    out  last response was a DIV by zero, held likewise
// ----------------------------------------------------------------------------
module alu_mc
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [DATA_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rt,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  div_zero
);

   alu_state_e            state_q;
   logic [DATA_WIDTH-1:0] alu_out_q;
   logic                  div_zero_q;
   logic                  resp_valid_q;

   logic [DATA_WIDTH-1:0] alu_out_d;
   logic                  div_zero_d;
   logic [DATA_WIDTH-1:0] mul_lo;
   logic [2:0]            nzp;

   alu_op_e               op;
   logic                  accept;
   logic                  div_start;
   logic                  div_done;
   logic [DATA_WIDTH-1:0] div_quotient;

   assign op        = alu_op_e'(req_op);
   // Ready depends only on state/enable/reset, never on req_valid.
   assign req_ready = enable && (state_q == ST_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   // Divide by zero is answered in one cycle without touching the divider.
   assign div_start = accept && (op == OP_DIV) && (rt != '0);

   alu_divider #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_divider (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (rs),
      .divisor  (rt),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // Product truncated to the low half by the DATA_WIDTH-wide context.
   assign mul_lo = rs * rt;

   // Single-cycle datapath result for the operation being accepted.
   always_comb begin
      nzp           = '0;
      nzp[NZP_N]    = (rs < rt);
      nzp[NZP_Z]    = (rs == rt);
      nzp[NZP_P]    = (rs > rt);
      alu_out_d     = rs + rt;
      div_zero_d    = 1'b0;
      case (op)
         OP_SUB: alu_out_d = rs - rt;
         OP_MUL: alu_out_d = mul_lo;
         OP_DIV: begin
            // Only consumed when rt == 0; a real divide goes to the divider.
            alu_out_d  = '1;
            div_zero_d = 1'b1;
         end
         OP_CMP: alu_out_d = DATA_WIDTH'(nzp);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         alu_out_q    <= '0;
         div_zero_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (div_start) begin
                     state_q <= ST_DIV;
                  end else begin
                     alu_out_q    <= alu_out_d;
                     div_zero_q   <= div_zero_d;
                     resp_valid_q <= 1'b1;
                  end
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  alu_out_q    <= div_quotient;
                  div_zero_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign alu_out    = alu_out_q;
   assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// ----------------------------------------------------------------------------
// tb_alu_mc
// Directed-vector bench for alu_mc at DATA_WIDTH=8. Inputs change on the
// falling edge (or just after the rising edge); outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_op;
   logic [W-1:0] rs;
   logic [W-1:0] rt;
   logic         resp_valid;
   logic [W-1:0] alu_out;
   logic         div_zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_mc #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .rs         (rs),
      .rt         (rt),
      .resp_valid (resp_valid),
      .alu_out    (alu_out),
      .div_zero   (div_zero)
   );

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; req_valid = 1'b0; req_op = 3'd0; rs = '0; rt = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      n_vec++; if (alu_out !== 8'd0) begin n_err++; $display("FAIL reset_alu_out: got %0d expected 0", alu_out); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
      reset = 1'b0;
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_resp_valid: got %b expected 0", resp_valid); end
      n_vec++; if (alu_out !== 8'd0) begin n_err++; $display("FAIL idle_alu_out: got %0d expected 0", alu_out); end
   endtask

   task automatic test_add_mul();
      req_valid = 1'b1; req_op = 3'd0; rs = 8'd200; rt = 8'd100;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL add_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd44) begin n_err++; $display("FAIL add_result: got %0d expected 44", alu_out); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL add_ready: got %b expected 1", req_ready); end
      // Back-to-back MUL while the ADD response is showing.
      req_op = 3'd2; rs = 8'd16; rt = 8'd17;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL mul_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd16) begin n_err++; $display("FAIL mul_result: got %0d expected 16", alu_out); end
      req_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mul_pulse_len: got %b expected 0", resp_valid); end
      n_vec++; if (alu_out !== 8'd16) begin n_err++; $display("FAIL mul_hold: got %0d expected 16", alu_out); end
   endtask

   task automatic test_cmp();
      logic [W-1:0] a_tab [3];
      logic [W-1:0] b_tab [3];
      logic [W-1:0] e_tab [3];
      a_tab = '{8'd5, 8'd9, 8'd200};
      b_tab = '{8'd9, 8'd9, 8'd3};
      e_tab = '{8'b001, 8'b010, 8'b100};
      req_valid = 1'b1; req_op = 3'd4; rs = a_tab[0]; rt = b_tab[0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL cmp%0d_resp_valid: got %b expected 1", i, resp_valid); end
         n_vec++; if (alu_out !== e_tab[i]) begin n_err++; $display("FAIL cmp%0d_result: got %b expected %b", i, alu_out, e_tab[i]); end
         if (i < 2) begin rs = a_tab[i+1]; rt = b_tab[i+1]; end
      end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_div();
      req_valid = 1'b1; req_op = 3'd3; rs = 8'd200; rt = 8'd7;
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL div_ready_at_issue: got %b expected 1", req_ready); end
      @(posedge clk);
      #1;
      // Keep a follow-up request pending through the whole divide.
      req_op = 3'd0; rs = 8'd10; rt = 8'd20;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL div_busy_ready c%0d: got %b expected 0", c, req_ready); end
         n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL div_busy_resp c%0d: got %b expected 0", c, resp_valid); end
         n_vec++; if (alu_out !== 8'd4) begin n_err++; $display("FAIL div_busy_hold c%0d: got %0d expected 4", c, alu_out); end
      end
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL div_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd28) begin n_err++; $display("FAIL div_quotient: got %0d expected 28", alu_out); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL div_div_zero: got %b expected 0", div_zero); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL div_done_ready: got %b expected 1", req_ready); end
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL held_req_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd30) begin n_err++; $display("FAIL held_req_result: got %0d expected 30", alu_out); end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_div_zero();
      req_valid = 1'b1; req_op = 3'd3; rs = 8'd77; rt = 8'd0;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL divz_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd255) begin n_err++; $display("FAIL divz_result: got %0d expected 255", alu_out); end
      n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL divz_flag: got %b expected 1", div_zero); end
      req_op = 3'd0; rs = 8'd1; rt = 8'd1;
      @(negedge clk);
      n_vec++; if (alu_out !== 8'd2) begin n_err++; $display("FAIL divz_add_result: got %0d expected 2", alu_out); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL divz_add_clear: got %b expected 0", div_zero); end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      req_valid = 1'b1; req_op = 3'd3; rs = 8'd255; rt = 8'd1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL abort_pre_resp c%0d: got %b expected 0", c, resp_valid); end
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL abort_reset_ready: got %b expected 0", req_ready); end
      reset = 1'b0;
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL abort_post_ready: got %b expected 1", req_ready); end
      n_vec++; if (alu_out !== 8'd0) begin n_err++; $display("FAIL abort_alu_out: got %0d expected 0", alu_out); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL abort_div_zero: got %b expected 0", div_zero); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_resp c%0d: got %b expected 0", c, resp_valid); end
      end
      req_valid = 1'b1; req_op = 3'd1; rs = 8'd3; rt = 8'd5;
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL sub_resp_valid: got %b expected 1", resp_valid); end
      n_vec++; if (alu_out !== 8'd254) begin n_err++; $display("FAIL sub_result: got %0d expected 254", alu_out); end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_mul();
      test_cmp();
      test_div();
      test_div_zero();
      test_reset_mid_div();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
